// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the core request/response handshake and the data-memory bus of
//   the load/store unit.
//
//   master modport : the LSU itself (accepts core requests, initiates memory
//                    transactions, returns responses)
//   slave modport  : the surrounding environment (core + data memory)
//
//   Core request : req_valid, req_ready, req_we, req_size, req_unsigned,
//                  req_addr, req_wdata
//   Core response: resp_valid, resp_ready, resp_rdata, resp_err
//   Memory bus   : mem_req, mem_we, mem_addr, mem_wdata, mem_be,
//                  mem_rdata, mem_ack
// ----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Core-side initiator for a byte-addressed, big-endian data memory.
//   Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned memory
//   transactions with byte enables, splits accesses crossing a word boundary
//   into two transactions, sign/zero-extends loads and aborts transactions
//   that wait longer than TIMEOUT cycles (TIMEOUT = 0 disables the abort).
//
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : load_store_unit_if.master (core request/response + memory bus)
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int          ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    load_store_unit_if.master   bus
);
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [63:0]       rd_q;      // {first word, second word} as read
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0]        off;
    logic [3:0]        be_n;
    logic [7:0]        be_pair;
    logic [31:0]       wd_left;
    logic [63:0]       wd_pair;
    logic [63:0]       rd_shift;
    logic [31:0]       ld_left;
    logic [31:0]       ld_ext;
    logic              split;
    logic              timeout_hit;
    logic [ADDR_W-1:0] base_addr;

    // The access is viewed as an 8-byte window spanning the aligned word and
    // its successor: left-justified data and enables are shifted right by the
    // byte offset, the upper half feeds ACC1 and the lower half feeds ACC2.
    always_comb begin
        off = addr_q[1:0];
        case (size_q)
            2'b00:   be_n = 4'b1000;
            2'b01:   be_n = 4'b1100;
            default: be_n = 4'b1111;
        endcase
        case (size_q)
            2'b00:   wd_left = {wdata_q[7:0], 24'b0};
            2'b01:   wd_left = {wdata_q[15:0], 16'b0};
            default: wd_left = wdata_q;
        endcase
        be_pair  = {be_n, 4'b0} >> off;
        wd_pair  = {wd_left, 32'b0} >> {off, 3'b000};
        split    = |be_pair[3:0];

        rd_shift = rd_q << {off, 3'b000};
        ld_left  = rd_shift[63:32];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_left[31]}}, ld_left[31:24]};
            2'b01:   ld_ext = {{16{~uns_q & ld_left[31]}}, ld_left[31:16]};
            default: ld_ext = ld_left;
        endcase

        base_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        timeout_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    uns_q   <= bus.req_unsigned;
                    size_q  <= bus.req_size;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    err_q   <= (bus.req_size == 2'b11);
                    cnt_q   <= '0;
                end
                ACC1, ACC2: begin
                    if (bus.mem_ack) begin
                        cnt_q <= '0;
                        if (state_q == ACC1) rd_q[63:32] <= bus.mem_rdata;
                        else                 rd_q[31:0]  <= bus.mem_rdata;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_be     = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_d = (bus.req_size == 2'b11) ? RESP : ACC1;
            end
            ACC1: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = base_addr;
                bus.mem_be    = be_pair[7:4];
                bus.mem_wdata = we_q ? wd_pair[63:32] : '0;
                if (bus.mem_ack)      state_d = split ? ACC2 : RESP;
                else if (timeout_hit) state_d = RESP;
            end
            ACC2: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = base_addr + ADDR_W'(4);
                bus.mem_be    = be_pair[3:0];
                bus.mem_wdata = we_q ? wd_pair[31:0] : '0;
                if (bus.mem_ack || timeout_hit) state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (!we_q && !err_q) ? ld_ext : '0;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int          ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Memory seen by the DUT (dmem) and the reference byte image (rmem)
    logic [7:0] dmem [0:255];
    logic [7:0] rmem [0:255];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;
    txn_t txlog[$];

    // Responder modes: 0 zero-wait, 1 random wait, 2 never ack, 3 stall stall_addr
    int          rmode      = 0;
    logic [31:0] stall_addr = '0;
    int          waits      = 0;

    initial begin : responder
        bit pending;
        int wait_left;
        int a;
        txn_t t;
        logic [31:0] lanes;
        pending = 0;
        wait_left = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst || !bus.mem_req) begin
                bus.mem_ack = 1'b0;
                bus.mem_rdata = $urandom;
                pending = 0;
            end else begin
                if (!pending) begin
                    pending = 1;
                    wait_left = (rmode == 1) ? $urandom_range(0, 3) : 0;
                end
                if (rmode == 2 || (rmode == 3 && bus.mem_addr == stall_addr) || wait_left > 0) begin
                    bus.mem_ack = 1'b0;
                    bus.mem_rdata = $urandom;
                    waits++;
                    if (wait_left > 0) wait_left--;
                end else begin
                    a = int'(bus.mem_addr[7:0]);
                    chk("mem_addr_aligned", {30'b0, bus.mem_addr[1:0]}, 32'h0);
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = {dmem[a], dmem[a+1], dmem[a+2], dmem[a+3]};
                    t.addr = bus.mem_addr;
                    t.we = bus.mem_we;
                    t.be = bus.mem_be;
                    t.wdata = bus.mem_wdata;
                    txlog.push_back(t);
                    if (bus.mem_we) begin
                        lanes = '0;
                        for (int i = 0; i < 4; i++) begin
                            if (bus.mem_be[i]) begin
                                dmem[a + 3 - i] = bus.mem_wdata[8*i +: 8];
                                lanes[8*i +: 8] = 8'hFF;
                            end
                        end
                        chk("unused_wdata_lanes", bus.mem_wdata & ~lanes, 32'h0);
                    end
                    pending = 0;
                end
            end
        end
    end

    // Reference: byte-level big-endian semantics applied to rmem
    function automatic logic [31:0] model_req(input bit we, input bit [1:0] size, input bit uns,
                                              input int unsigned addr, input logic [31:0] wdata,
                                              output bit err, output int base_lat);
        int n;
        logic [31:0] v;
        if (size == 2'b11) begin
            err = 1;
            base_lat = 1;
            return 32'h0;
        end
        n = 1 << size;
        err = 0;
        base_lat = ((addr % 4) + n > 4) ? 3 : 2;
        if (we) begin
            for (int k = 0; k < n; k++) rmem[addr + k] = 8'(wdata >> (8 * (n - 1 - k)));
            return 32'h0;
        end
        v = '0;
        for (int k = 0; k < n; k++) v = (v << 8) | 32'(rmem[addr + k]);
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic void chk_mem();
        int bad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== rmem[i]) bad++;
        chk("mem_image", bad, 0);
    endfunction

    task automatic run_req(input bit we, input bit [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                           output logic [31:0] rd, output logic err, output int lat, output int nw);
        int g;
        logic [33:0] snap;
        @(negedge clk);
        g = 0;
        while (!bus.req_ready && g < 20) begin @(negedge clk); g++; end
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        waits = 0;
        txlog.delete();
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) break;
            if (lat > 100) begin
                checks++;
                failures++;
                $display("FAIL resp_wait: got no resp_valid expected one within 100 cycles");
                break;
            end
        end
        rd = bus.resp_rdata;
        err = bus.resp_err;
        nw = waits;
        snap = {bus.resp_valid, bus.resp_err, bus.resp_rdata};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("resp_hold_stable", 32'({bus.resp_valid, bus.resp_err, bus.resp_rdata} != snap), 32'h0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    typedef struct {
        bit          we;
        bit [1:0]    size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          pre;
        logic [31:0] pre0;
        logic [31:0] pre1;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        logic [3:0]  exp_be1;
        int          exp_ntx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit we, bit [1:0] size, bit uns, logic [31:0] addr, logic [31:0] wdata,
                                bit pre, logic [31:0] pre0, logic [31:0] pre1, logic [31:0] exp_rd,
                                bit exp_err, int exp_lat, logic [3:0] exp_be1, int exp_ntx);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.pre = pre; v.pre0 = pre0; v.pre1 = pre1; v.exp_rd = exp_rd; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_be1 = exp_be1; v.exp_ntx = exp_ntx;
        return v;
    endfunction

    function automatic void preload(logic [31:0] addr, logic [31:0] w0, logic [31:0] w1);
        int b = int'(addr[7:0]) & 'hFC;
        for (int i = 0; i < 4; i++) begin
            dmem[b + i]     = w0[31 - 8*i -: 8];
            rmem[b + i]     = w0[31 - 8*i -: 8];
            dmem[b + 4 + i] = w1[31 - 8*i -: 8];
            rmem[b + 4 + i] = w1[31 - 8*i -: 8];
        end
    endfunction

    initial begin : main
        logic [31:0] rd, exp_rd, wd, ad;
        logic err;
        bit exp_err, we, uns;
        bit [1:0] sz;
        int lat, nw, base_lat, cnt, hold;

        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = '0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin dmem[i] = '0; rmem[i] = '0; end

        // Reset state
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_bus", {bus.mem_addr[27:0], bus.mem_be} | bus.mem_wdata | 32'(bus.mem_we), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table, zero-wait memory
        vecs.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0, 1, 32'h11223344, 32'h0, 32'h11223344, 0, 2, 4'b1111, 1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h05, 32'h0, 1, 32'hAA80CCDD, 32'h0, 32'hFFFFFF80, 0, 2, 4'b0100, 1));
        vecs.push_back(mk(0, 2'b00, 1, 32'h05, 32'h0, 0, 32'h0, 32'h0, 32'h00000080, 0, 2, 4'b0100, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h06, 32'h0, 1, 32'h0102AABB, 32'hCCDD0304, 32'hAABBCCDD, 0, 3, 4'b0011, 2));
        vecs.push_back(mk(0, 2'b01, 0, 32'h03, 32'h0, 1, 32'h000000F1, 32'h23000000, 32'hFFFFF123, 0, 3, 4'b0001, 2));
        vecs.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0, 1, 32'h12348000, 32'h0, 32'h00008000, 0, 2, 4'b0011, 1));
        vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0, 0, 32'h0, 32'h0, 32'hFFFF8000, 0, 2, 4'b0011, 1));
        vecs.push_back(mk(0, 2'b11, 0, 32'h20, 32'h0, 0, 32'h0, 32'h0, 32'h00000000, 1, 1, 4'b0000, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 32'h00000000, 1, 1, 4'b0000, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h21, 32'hDEADBEEF, 1, 32'h0, 32'h0, 32'h00000000, 0, 3, 4'b0111, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h0, 32'h0, 32'h00DEADBE, 0, 2, 4'b1111, 1));
        vecs.push_back(mk(0, 2'b00, 1, 32'h24, 32'h0, 0, 32'h0, 32'h0, 32'h000000EF, 0, 2, 4'b1000, 1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h2B, 32'hFFFFFF5A, 1, 32'h01020304, 32'h0, 32'h00000000, 0, 2, 4'b0001, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h28, 32'h0, 0, 32'h0, 32'h0, 32'h0102035A, 0, 2, 4'b1111, 1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h2B, 32'h0, 0, 32'h0, 32'h0, 32'h0000005A, 0, 2, 4'b0001, 1));

        rmode = 0;
        foreach (vecs[i]) begin
            if (vecs[i].pre) preload(vecs[i].addr, vecs[i].pre0, vecs[i].pre1);
            void'(model_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, exp_err, base_lat));
            run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, i % 3, rd, err, lat, nw);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_ntxn", i), txlog.size(), vecs[i].exp_ntx);
            if (txlog.size() > 0) chk($sformatf("vec%0d_be1", i), 32'(txlog[0].be), 32'(vecs[i].exp_be1));
        end
        chk_mem();

        // SH 0x3: two transactions with big-endian lane placement
        void'(model_req(1, 2'b01, 0, 32'h03, 32'h0000BEEF, exp_err, base_lat));
        run_req(1, 2'b01, 0, 32'h03, 32'h0000BEEF, 0, rd, err, lat, nw);
        chk("sh_split_ntxn", txlog.size(), 2);
        if (txlog.size() == 2) begin
            chk("sh_txn1_addr", txlog[0].addr, 32'h0);
            chk("sh_txn1_be", 32'(txlog[0].be), 32'h1);
            chk("sh_txn1_wdata", txlog[0].wdata, 32'h000000BE);
            chk("sh_txn2_addr", txlog[1].addr, 32'h4);
            chk("sh_txn2_be", 32'(txlog[1].be), 32'h8);
            chk("sh_txn2_wdata", txlog[1].wdata, 32'hEF000000);
        end
        chk_mem();

        // Timeout: memory never acknowledges
        rmode = 2;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h40;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        cnt = 0;
        while (1) begin
            @(negedge clk);
            if (!bus.mem_req || cnt > 60) break;
            cnt++;
        end
        chk("tmo_req_cycles", cnt, TIMEOUT);
        chk("tmo_resp_valid", 32'(bus.resp_valid), 32'h1);
        chk("tmo_resp_err", 32'(bus.resp_err), 32'h1);
        chk("tmo_resp_rdata", bus.resp_rdata, 32'h0);
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            chk("tmo_hold", {bus.resp_rdata[29:0], bus.resp_valid, bus.resp_err}, 32'h3);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;

        // Reset while the second half of a split SW is pending
        rmode = 3;
        stall_addr = 32'h34;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h32; bus.req_wdata = 32'h11223344;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_addr == 32'h34) break;
            cnt++;
        end
        chk("rst_acc2_reached", 32'(cnt < 20), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_async_req_ready", 32'(bus.req_ready), 32'h1);
        rmem[8'h32] = 8'h11;
        rmem[8'h33] = 8'h22;
        @(negedge clk);
        rst = 1'b1;
        rmode = 0;
        exp_rd = model_req(0, 2'b10, 0, 32'h30, 32'h0, exp_err, base_lat);
        run_req(0, 2'b10, 0, 32'h30, 32'h0, 0, rd, err, lat, nw);
        chk("post_rst_lw_rdata", rd, exp_rd);
        chk("post_rst_lw_err", 32'(err), 32'h0);
        chk("post_rst_lw_latency", lat, 2);
        chk_mem();

        // Randomized traffic against the reference model
        rmode = 1;
        for (int it = 0; it < 300; it++) begin
            we = 1'($urandom);
            uns = 1'($urandom);
            sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = $urandom_range(0, 240);
            wd = $urandom;
            hold = $urandom_range(0, 2);
            exp_rd = model_req(we, sz, uns, ad, wd, exp_err, base_lat);
            run_req(we, sz, uns, ad, wd, hold, rd, err, lat, nw);
            chk($sformatf("rnd%0d_rdata", it), rd, exp_rd);
            chk($sformatf("rnd%0d_err", it), 32'(err), 32'(exp_err));
            chk($sformatf("rnd%0d_latency", it), lat, base_lat + nw);
            if (it % 25 == 24) chk_mem();
        end
        chk_mem();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
